// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2**N line decoder with two modes.
// Direct mode decodes sel_in on a valid/ready handshake. Auto-scan mode
// walks every line in turn and holds each one for dwell+1 cycles.
// ACTIVE_LOW inverts the out bus so that the active line is the only zero.
module scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  wrap
);

    localparam int N = 2**SEL_W;

    // XOR mask applied to the internal one-hot value on the way out.
    localparam logic [N-1:0] POL_MASK = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};
    localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // One-hot of x. Indexing a cleared vector avoids the shift truncation
    // that a 32-bit literal shift could introduce for wide SEL_W.
    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] x);
        logic [N-1:0] v;
        v    = {N{1'b0}};
        v[x] = 1'b1;
        return v;
    endfunction

    state_t               state_r, state_nx_s;
    logic [N-1:0]         out_r;
    logic [N-1:0]         hot_s, hot_nx_s;
    logic                 valid_r, valid_nx_s;
    logic [SEL_W-1:0]     sel_r, sel_nx_s;
    logic                 wrap_r, wrap_nx_s;
    logic                 ready_r;
    logic [DWELL_W-1:0]   dcnt_r, dcnt_nx_s;
    logic [DWELL_W-1:0]   dlen_r, dlen_nx_s;

    // Active-high view of the currently driven line, used for holding.
    assign hot_s = out_r ^ POL_MASK;

    // Next state and next registered output values.
    always_comb begin
        state_nx_s = state_r;
        hot_nx_s   = hot_s;
        valid_nx_s = valid_r;
        sel_nx_s   = sel_r;
        wrap_nx_s  = 1'b0;
        dcnt_nx_s  = dcnt_r;
        dlen_nx_s  = dlen_r;

        // Enable dominates; with en high, mode alone selects the target.
        if (!en) begin
            state_nx_s = ST_IDLE;
        end else if (mode) begin
            state_nx_s = ST_SCAN;
        end else begin
            state_nx_s = ST_DIRECT;
        end

        case (state_nx_s)
            ST_IDLE: begin
                hot_nx_s   = {N{1'b0}};
                valid_nx_s = 1'b0;
                sel_nx_s   = {SEL_W{1'b0}};
                dcnt_nx_s  = {DWELL_W{1'b0}};
                dlen_nx_s  = {DWELL_W{1'b0}};
            end
            ST_DIRECT: begin
                if (state_r != ST_DIRECT) begin
                    // Fresh entry: nothing is valid until a handshake lands.
                    hot_nx_s   = {N{1'b0}};
                    valid_nx_s = 1'b0;
                    sel_nx_s   = {SEL_W{1'b0}};
                    dcnt_nx_s  = {DWELL_W{1'b0}};
                end else if (in_valid && ready_r) begin
                    hot_nx_s   = decode(sel_in);
                    valid_nx_s = 1'b1;
                    sel_nx_s   = sel_in;
                end else begin
                    hot_nx_s   = hot_s;
                    valid_nx_s = valid_r;
                end
            end
            ST_SCAN: begin
                if (state_r != ST_SCAN) begin
                    // Scan always restarts at line 0; a handshake accepted
                    // on the switching edge is overridden here.
                    hot_nx_s   = decode({SEL_W{1'b0}});
                    valid_nx_s = 1'b1;
                    sel_nx_s   = {SEL_W{1'b0}};
                    dcnt_nx_s  = {DWELL_W{1'b0}};
                    dlen_nx_s  = dwell;
                end else if (dcnt_r == dlen_r) begin
                    // Line finished: advance and latch dwell for the new line.
                    sel_nx_s   = sel_r + SEL_W'(1'b1);
                    hot_nx_s   = decode(sel_r + SEL_W'(1'b1));
                    valid_nx_s = 1'b1;
                    wrap_nx_s  = (sel_r == SEL_MAX);
                    dcnt_nx_s  = {DWELL_W{1'b0}};
                    dlen_nx_s  = dwell;
                end else begin
                    dcnt_nx_s  = dcnt_r + DWELL_W'(1'b1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                hot_nx_s   = {N{1'b0}};
                valid_nx_s = 1'b0;
                sel_nx_s   = {SEL_W{1'b0}};
                dcnt_nx_s  = {DWELL_W{1'b0}};
                dlen_nx_s  = {DWELL_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset forces the idle picture at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            out_r   <= POL_MASK;
            valid_r <= 1'b0;
            sel_r   <= {SEL_W{1'b0}};
            wrap_r  <= 1'b0;
            ready_r <= 1'b0;
            dcnt_r  <= {DWELL_W{1'b0}};
            dlen_r  <= {DWELL_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            out_r   <= hot_nx_s ^ POL_MASK;
            valid_r <= valid_nx_s;
            sel_r   <= sel_nx_s;
            wrap_r  <= wrap_nx_s;
            ready_r <= (state_nx_s == ST_DIRECT);
            dcnt_r  <= dcnt_nx_s;
            dlen_r  <= dlen_nx_s;
        end
    end

    assign out       = out_r;
    assign out_valid = valid_r;
    assign cur_sel   = sel_r;
    assign wrap      = wrap_r;
    assign in_ready  = ready_r;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder: a default instance
// (SEL_W=3) and an active-low instance (SEL_W=2).
module tb_scan_decoder;

    logic       clk;
    logic       rst, en, mode, in_valid;
    logic [2:0] sel_in;
    logic [3:0] dwell;
    logic       in_ready, out_valid, wrap;
    logic [7:0] out;
    logic [2:0] cur_sel;

    logic       rst_al, en_al, mode_al, in_valid_al;
    logic [1:0] sel_in_al;
    logic [3:0] dwell_al;
    logic       in_ready_al, out_valid_al, wrap_al;
    logic [3:0] out_al;
    logic [1:0] cur_sel_al;

    int checks;
    int failures;

    scan_decoder dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .sel_in(sel_in),
        .dwell(dwell), .out(out), .out_valid(out_valid),
        .cur_sel(cur_sel), .wrap(wrap)
    );

    scan_decoder #(.SEL_W(2), .DWELL_W(4), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst_al), .en(en_al), .mode(mode_al),
        .in_valid(in_valid_al), .in_ready(in_ready_al), .sel_in(sel_in_al),
        .dwell(dwell_al), .out(out_al), .out_valid(out_valid_al),
        .cur_sel(cur_sel_al), .wrap(wrap_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", out); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
        checks++; if (cur_sel !== 3'd0 || wrap !== 1'b0) begin failures++; $display("FAIL reset_sel_wrap got=%0d/%b exp=0/0", cur_sel, wrap); end
        checks++; if (out_al !== 4'hF) begin failures++; $display("FAIL reset_out_al got=%h exp=F", out_al); end
        rst = 1'b0;
        rst_al = 1'b0;
        tick();
    endtask

    task automatic test_direct_sweep();
        logic [7:0] exp;
        en = 1'b1; mode = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL direct_entry ready/valid got=%b/%b exp=1/0", in_ready, out_valid); end
        for (int i = 0; i < 8; i++) begin
            sel_in = 3'(i); in_valid = 1'b1;
            tick();
            exp = 8'h01 << i;
            checks++; if (out !== exp || cur_sel !== 3'(i) || out_valid !== 1'b1) begin
                failures++; $display("FAIL direct_sweep[%0d] got=%h/%0d/%b exp=%h/%0d/1", i, out, cur_sel, out_valid, exp, i);
            end
        end
        in_valid = 1'b0; sel_in = 3'd2;
        tick();
        tick();
        checks++; if (out !== 8'h80 || cur_sel !== 3'd7 || out_valid !== 1'b1) begin failures++; $display("FAIL direct_hold got=%h/%0d/%b exp=80/7/1", out, cur_sel, out_valid); end
    endtask

    task automatic test_en_drop_mode_switch();
        sel_in = 3'd5; in_valid = 1'b1;
        tick();
        checks++; if (out !== 8'h20) begin failures++; $display("FAIL pre_drop_out got=%h exp=20", out); end
        en = 1'b0; sel_in = 3'd3; in_valid = 1'b1;
        tick();
        checks++; if (out !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b0 || cur_sel !== 3'd0) begin
            failures++; $display("FAIL en_drop got=%h/%b/%b/%0d exp=00/0/0/0", out, out_valid, in_ready, cur_sel);
        end
        en = 1'b1; mode = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out !== 8'h00 || in_ready !== 1'b1) begin failures++; $display("FAIL direct_reentry got=%h/%b/%b exp=00/0/1", out, out_valid, in_ready); end
        sel_in = 3'd5; in_valid = 1'b1;
        tick();
        checks++; if (out !== 8'h20 || cur_sel !== 3'd5) begin failures++; $display("FAIL direct_5 got=%h/%0d exp=20/5", out, cur_sel); end
        in_valid = 1'b0; mode = 1'b1;
        tick();
        checks++; if (out !== 8'h01 || cur_sel !== 3'd0 || out_valid !== 1'b1 || in_ready !== 1'b0 || wrap !== 1'b0) begin
            failures++; $display("FAIL mode_switch got=%h/%0d/%b/%b/%b exp=01/0/1/0/0", out, cur_sel, out_valid, in_ready, wrap);
        end
    endtask

    task automatic test_scan_dwell0();
        logic [7:0] exp;
        en = 1'b0; mode = 1'b1; dwell = 4'd0;
        tick();
        en = 1'b1;
        tick();
        checks++; if (out !== 8'h01 || wrap !== 1'b0) begin failures++; $display("FAIL scan0_entry got=%h/%b exp=01/0", out, wrap); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = 8'h01 << (i % 8);
            checks++; if (out !== exp || cur_sel !== 3'(i % 8) || wrap !== (i == 8)) begin
                failures++; $display("FAIL scan0[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, out, cur_sel, wrap, exp, i % 8, (i == 8));
            end
        end
        tick();
        checks++; if (out !== 8'h02 || wrap !== 1'b0) begin failures++; $display("FAIL scan0_post_wrap got=%h/%b exp=02/0", out, wrap); end
    endtask

    task automatic test_scan_dwell2();
        logic [7:0] exp;
        int line;
        en = 1'b0; mode = 1'b1; dwell = 4'd2;
        tick();
        en = 1'b1;
        tick();
        for (int c = 0; c <= 25; c++) begin
            line = (c / 3) % 8;
            exp = 8'h01 << line;
            checks++; if (out !== exp || cur_sel !== 3'(line) || wrap !== (c == 24) || in_ready !== 1'b0) begin
                failures++; $display("FAIL scan2[%0d] got=%h/%0d/%b/%b exp=%h/%0d/%b/0", c, out, cur_sel, wrap, in_ready, exp, line, (c == 24));
            end
            if (c == 7) begin
                in_valid = 1'b1; sel_in = 3'd5;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0; mode = 1'b1; dwell = 4'd0;
        tick();
        en = 1'b1;
        tick();
        tick(); tick(); tick(); tick();
        checks++; if (cur_sel !== 3'd4 || out !== 8'h10) begin failures++; $display("FAIL pre_reset got=%0d/%h exp=4/10", cur_sel, out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out !== 8'h00 || out_valid !== 1'b0 || cur_sel !== 3'd0) begin
            failures++; $display("FAIL async_reset got=%h/%b/%0d exp=00/0/0", out, out_valid, cur_sel);
        end
        #2 rst = 1'b0;
        #1;
        checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin failures++; $display("FAIL after_release got=%h/%b exp=00/0", out, out_valid); end
        tick();
        checks++; if (out !== 8'h01 || cur_sel !== 3'd0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL scan_restart got=%h/%0d/%b exp=01/0/1", out, cur_sel, out_valid);
        end
    endtask

    task automatic test_active_low();
        en_al = 1'b1; mode_al = 1'b0;
        tick();
        checks++; if (out_al !== 4'hF || in_ready_al !== 1'b1 || out_valid_al !== 1'b0) begin
            failures++; $display("FAIL al_entry got=%h/%b/%b exp=F/1/0", out_al, in_ready_al, out_valid_al);
        end
        sel_in_al = 2'd2; in_valid_al = 1'b1;
        tick();
        checks++; if (out_al !== 4'hB || out_valid_al !== 1'b1 || cur_sel_al !== 2'd2) begin
            failures++; $display("FAIL al_sel2 got=%h/%b/%0d exp=B/1/2", out_al, out_valid_al, cur_sel_al);
        end
        sel_in_al = 2'd0;
        tick();
        checks++; if (out_al !== 4'hE) begin failures++; $display("FAIL al_sel0 got=%h exp=E", out_al); end
        in_valid_al = 1'b0; en_al = 1'b0;
        tick();
        checks++; if (out_al !== 4'hF || out_valid_al !== 1'b0) begin failures++; $display("FAIL al_idle got=%h/%b exp=F/0", out_al, out_valid_al); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel_in = 3'd0; dwell = 4'd0;
        rst_al = 1'b1; en_al = 1'b0; mode_al = 1'b0; in_valid_al = 1'b0; sel_in_al = 2'd0; dwell_al = 4'd0;
        test_reset();
        test_direct_sweep();
        test_en_drop_mode_switch();
        test_scan_dwell0();
        test_scan_dwell2();
        test_async_reset();
        test_active_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
